// File: rtl/mips_pkg.sv
// Shared definitions for the sequential MIPS multiplier.
// Holds the FSM state encoding and the fixed datapath widths:
//   DataW - operand / HI / LO width
//   PartW - 16x32 partial product width
//   ProdW - full HI:LO product width
package mips_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned PartW = 48;
  localparam int unsigned ProdW = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlo  = 2'd1,
    StPhi  = 2'd2,
    StFin  = 2'd3
  } mult_state_e;

endpackage

// File: rtl/mips_mult.sv
// Combinational 16x32 multiply stage plus final product assembly.
// Ports:
//   acompl, bcompl - operand sign flags; the product is negated when they differ
//   a, b           - 16-bit slice of |rs| and full |rt| for this pass
//   partprod_h/_l  - registered partial products of the upper / lower pass
//   partproduct    - a * b (unsigned, 48 bits)
//   product        - ((partprod_h << 16) + partprod_l), sign-corrected
module mips_mult
  import mips_pkg::*;
(
  input  logic             acompl,
  input  logic             bcompl,
  input  logic [15:0]      a,
  input  logic [DataW-1:0] b,
  input  logic [PartW-1:0] partprod_h,
  input  logic [PartW-1:0] partprod_l,
  output logic [PartW-1:0] partproduct,
  output logic [ProdW-1:0] product
);

  logic [ProdW-1:0] mag_sum;

  always_comb begin
    partproduct = {32'd0, a} * {16'd0, b};
    mag_sum     = {partprod_h, 16'd0} + {16'd0, partprod_l};
    product     = (acompl ^ bcompl) ? -mag_sum : mag_sum;
  end

endmodule

// File: rtl/mips_multseq.sv
// Sequential MULT/MULTU unit with HI/LO registers.
// Operands are reduced to magnitudes at start, multiplied in two 16x32 passes
// (PLO, PHI), then combined and sign-corrected in FIN.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, sgn      - begin a multiply (sampled in idle); 1 = signed
//   rs, rt          - operands, sampled with start
//   hi_we, lo_we    - MTHI/MTLO strobes (idle only), data on wdata
//   busy, done      - op in flight; one-cycle pulse when the product appears
//   hi, lo          - HI/LO registers (show the product during the done cycle)
module mips_multseq
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [DataW-1:0] rs,
  input  logic [DataW-1:0] rt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [DataW-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [DataW-1:0] hi,
  output logic [DataW-1:0] lo
);

  mult_state_e      state_q, state_d;
  logic             acompl_q, acompl_d;
  logic             bcompl_q, bcompl_d;
  logic [DataW-1:0] amag_q, amag_d;
  logic [DataW-1:0] bmag_q, bmag_d;
  logic [PartW-1:0] pp_l_q, pp_l_d;
  logic [PartW-1:0] pp_h_q, pp_h_d;
  logic [DataW-1:0] hi_q, hi_d;
  logic [DataW-1:0] lo_q, lo_d;

  logic [15:0]      stage_a;
  logic [PartW-1:0] partproduct;
  logic [ProdW-1:0] product;

  mips_mult u_mult (
    .acompl     (acompl_q),
    .bcompl     (bcompl_q),
    .a          (stage_a),
    .b          (bmag_q),
    .partprod_h (pp_h_q),
    .partprod_l (pp_l_q),
    .partproduct(partproduct),
    .product    (product)
  );

  always_comb begin
    state_d  = state_q;
    acompl_d = acompl_q;
    bcompl_d = bcompl_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    pp_l_d   = pp_l_q;
    pp_h_d   = pp_h_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stage_a  = '0;
    unique case (state_q)
      StIdle: begin
        // A write together with start still lands; FIN overwrites it later.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          acompl_d = sgn & rs[DataW-1];
          bcompl_d = sgn & rt[DataW-1];
          // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
          amag_d   = acompl_d ? -rs : rs;
          bmag_d   = bcompl_d ? -rt : rt;
          state_d  = StPlo;
        end
      end
      StPlo: begin
        stage_a = amag_q[15:0];
        pp_l_d  = partproduct;
        state_d = StPhi;
      end
      StPhi: begin
        stage_a = amag_q[31:16];
        pp_h_d  = partproduct;
        state_d = StFin;
      end
      StFin: begin
        {hi_d, lo_d} = product;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acompl_q <= 1'b0;
      bcompl_q <= 1'b0;
      amag_q   <= '0;
      bmag_q   <= '0;
      pp_l_q   <= '0;
      pp_h_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acompl_q <= acompl_d;
      bcompl_q <= bcompl_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      pp_l_q   <= pp_l_d;
      pp_h_q   <= pp_h_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // The product is visible on hi/lo in the FIN cycle itself, before it is registered.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFin);
    hi   = done ? product[63:32] : hi_q;
    lo   = done ? product[31:0]  : lo_q;
  end

endmodule

// File: tb/tb_mips_multseq.sv
module tb_mips_multseq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [63:0] exp_q[$];

  mips_multseq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sgn  (sgn),
    .rs   (rs),
    .rt   (rt),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else check("product", {hi, lo}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply in the current (idle) cycle and follow it to idle again.
  task automatic do_mul(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    start = 1'b1; sgn = s; rs = a; rt = b;
    exp_q.push_back(model(s, a, b));
    exp_done++;
    tick();
    // Operands must not matter after the start edge.
    start = 1'b0; sgn = 1'($urandom); rs = $urandom; rt = $urandom;
    check({tag, "_busy1"}, {63'd0, busy}, 64'd1);
    check({tag, "_done1"}, {63'd0, done}, 64'd0);
    tick();
    check({tag, "_busy2"}, {63'd0, busy}, 64'd1);
    tick();
    check({tag, "_busy3"}, {63'd0, busy}, 64'd1);
    check({tag, "_done3"}, {63'd0, done}, 64'd1);
    tick();
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    check({tag, "_hold"}, {hi, lo}, model(s, a, b));
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rsg;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; rs = '0; rt = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #13;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    // MTHI/MTLO together in idle.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_both", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
    check("wr_busy", {63'd0, busy}, 64'd0);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    lo_we = 1'b0;
    check("wr_lo_only", {hi, lo}, 64'hA5A5_A5A5_0000_1234);

    // Asynchronous reset clears HI/LO without a clock edge.
    #2 rst = 1'b1;
    #1 check("async_rst", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_mul(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, "mult_m2x3");
    do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1m1");
    do_mul(1'b0, 32'h8000_0000, 32'h0000_0002, "multu_msb");
    do_mul(1'b1, 32'h0000_0000, 32'h8765_4321, "mult_zero");

    // Start during PHI together with an MTHI: both must be ignored.
    start = 1'b1; sgn = 1'b0; rs = 32'h1234_5678; rt = 32'h0000_0010;
    exp_q.push_back(64'h0000_0001_2345_6780);
    exp_done++;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_DEAD; rs = 32'd5; rt = 32'd5;
    tick();
    start = 1'b0; hi_we = 1'b0;
    tick();
    check("ign_idle", {63'd0, busy}, 64'd0);
    check("ign_hold", {hi, lo}, 64'h0000_0001_2345_6780);
    tick();
    check("ign_norestart", {63'd0, busy}, 64'd0);

    // Start with a write in idle: the write shows first, FIN overwrites it.
    start = 1'b1; sgn = 1'b0; rs = 32'd3; rt = 32'd4; hi_we = 1'b1; wdata = 32'hCAFE_0000;
    exp_q.push_back(64'd12);
    exp_done++;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("wr_start_hi", {32'd0, hi}, {32'd0, 32'hCAFE_0000});
    tick(); tick(); tick();
    check("wr_start_res", {hi, lo}, 64'd12);

    // Reset during PHI aborts with no done pulse.
    start = 1'b1; sgn = 1'b0; rs = 32'hFFFF_0000; rt = 32'h0000_FFFF;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_mul(1'b0, 32'd7, 32'd6, "after_rst");

    // Back-to-back random operations.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rsg = 1'($urandom);
      do_mul(rsg, ra, rb, "rand");
    end

    tick();
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
